// File: rtl/dvi_pkg.sv
// Shared types and constants for the three-channel DVI TMDS encoder.
package dvi_pkg;

    typedef logic [9:0] tmds_sym_t;

    localparam tmds_sym_t TMDS_CTRL_00 = 10'b1101010100;
    localparam tmds_sym_t TMDS_CTRL_01 = 10'b0010101011;
    localparam tmds_sym_t TMDS_CTRL_10 = 10'b0101010100;
    localparam tmds_sym_t TMDS_CTRL_11 = 10'b1010101011;

    localparam int unsigned DispBound = 8;

    // Stage-1 payload handed to the DC-balancing stage.
    typedef struct packed {
        logic       de;
        logic       c1;
        logic       c0;
        logic [8:0] q_m;
        logic [3:0] n1;
        logic [3:0] n0;
    } tmds_stage_t;

    function automatic tmds_sym_t ctrl_token(input logic c1, input logic c0);
        tmds_sym_t tok;
        case ({c1, c0})
            2'b00:   tok = TMDS_CTRL_00;
            2'b01:   tok = TMDS_CTRL_01;
            2'b10:   tok = TMDS_CTRL_10;
            default: tok = TMDS_CTRL_11;
        endcase
        return tok;
    endfunction

endpackage

// File: rtl/dvi_encoder_if.sv
// Pixel/timing inputs and TMDS symbol outputs of the DVI encoder.
interface dvi_encoder_if;
    import dvi_pkg::*;

    logic      de;
    logic      hsync;
    logic      vsync;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    tmds_sym_t tmds_ch0;
    tmds_sym_t tmds_ch1;
    tmds_sym_t tmds_ch2;
    logic      disp_err;

    modport master (
        output de, hsync, vsync, r, g, b,
        input  tmds_ch0, tmds_ch1, tmds_ch2, disp_err
    );

    modport slave (
        input  de, hsync, vsync, r, g, b,
        output tmds_ch0, tmds_ch1, tmds_ch2, disp_err
    );

endinterface

// File: rtl/tmds_encoder.sv
// Single-channel two-stage TMDS encoder with running disparity.
// Optional disparity bound check built only with DVI_DISP_CHECK_EN.
module tmds_encoder
    import dvi_pkg::*;
#(
    parameter int unsigned DISPW = 6
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic       de,
    input  logic       c0,
    input  logic       c1,
    input  logic [7:0] d,
    output tmds_sym_t  sym
`ifdef DVI_DISP_CHECK_EN
    ,
    output logic       err
`endif
);

    tmds_stage_t s1_d, s1_q;
    logic [3:0]  d_ones;
    logic [3:0]  qm_ones;
    logic        use_xnor;
    logic [8:0]  q_m;

    always_comb begin
        d_ones = '0;
        for (int i = 0; i < 8; i++) begin
            d_ones = d_ones + 4'(d[i]);
        end
        use_xnor = (d_ones > 4'd4) || ((d_ones == 4'd4) && !d[0]);

        q_m    = '0;
        q_m[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q_m[i] = use_xnor ? ~(q_m[i-1] ^ d[i]) : (q_m[i-1] ^ d[i]);
        end
        q_m[8] = ~use_xnor;

        qm_ones = '0;
        for (int i = 0; i < 8; i++) begin
            qm_ones = qm_ones + 4'(q_m[i]);
        end

        s1_d.de  = de;
        s1_d.c1  = c1;
        s1_d.c0  = c0;
        s1_d.q_m = q_m;
        s1_d.n1  = qm_ones;
        s1_d.n0  = 4'd8 - qm_ones;
    end

    logic signed [DISPW-1:0] cnt_q, cnt_d;
    logic signed [DISPW-1:0] n1_s, n0_s, two_q8, two_nq8;
    logic                    cnt_pos, cnt_neg;
    tmds_sym_t               sym_d, sym_q;

    always_comb begin
        n1_s    = $signed(DISPW'(s1_q.n1));
        n0_s    = $signed(DISPW'(s1_q.n0));
        two_q8  = s1_q.q_m[8] ? DISPW'(2) : '0;
        two_nq8 = s1_q.q_m[8] ? '0 : DISPW'(2);
        cnt_neg = cnt_q[DISPW-1];
        cnt_pos = !cnt_q[DISPW-1] && (cnt_q != '0);
        sym_d   = TMDS_CTRL_00;
        cnt_d   = cnt_q;

        if (!s1_q.de) begin
            // Blanking always restarts DC balance from zero.
            sym_d = ctrl_token(s1_q.c1, s1_q.c0);
            cnt_d = '0;
        end else if ((cnt_q == '0) || (s1_q.n1 == s1_q.n0)) begin
            sym_d = {~s1_q.q_m[8], s1_q.q_m[8],
                     s1_q.q_m[8] ? s1_q.q_m[7:0] : ~s1_q.q_m[7:0]};
            cnt_d = s1_q.q_m[8] ? (cnt_q + n1_s - n0_s) : (cnt_q + n0_s - n1_s);
        end else if ((cnt_pos && (s1_q.n1 > s1_q.n0)) || (cnt_neg && (s1_q.n0 > s1_q.n1))) begin
            sym_d = {1'b1, s1_q.q_m[8], ~s1_q.q_m[7:0]};
            cnt_d = cnt_q + two_q8 + n0_s - n1_s;
        end else begin
            sym_d = {1'b0, s1_q.q_m[8], s1_q.q_m[7:0]};
            cnt_d = cnt_q - two_nq8 + n1_s - n0_s;
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            s1_q  <= '0;
            cnt_q <= '0;
            sym_q <= TMDS_CTRL_00;
        end else begin
            s1_q  <= s1_d;
            cnt_q <= cnt_d;
            sym_q <= sym_d;
        end
    end

    assign sym = sym_q;

`ifdef DVI_DISP_CHECK_EN
    localparam logic signed [DISPW-1:0] BoundPos = DISPW'(DispBound);
    localparam logic signed [DISPW-1:0] BoundNeg = -BoundPos;

    logic err_q;

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            err_q <= 1'b0;
        end else if ((cnt_d > BoundPos) || (cnt_d < BoundNeg)) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: rtl/dvi_encoder.sv
// Three-channel DVI TMDS encoder, two-cycle latency, one symbol per channel per clock.
// Define DVI_DISP_CHECK_EN to build the sticky running-disparity bound check.
module dvi_encoder
    import dvi_pkg::*;
#(
    parameter int unsigned DISPW = 6
) (
    input logic          clk_pix,
    input logic          rst_pix,
    dvi_encoder_if.slave bus
);

`ifdef DVI_DISP_CHECK_EN
    logic err_ch0, err_ch1, err_ch2;
`endif

    // Syncs ride on the blue channel only.
    tmds_encoder #(.DISPW(DISPW)) u_enc_b (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .de      (bus.de),
        .c0      (bus.hsync),
        .c1      (bus.vsync),
        .d       (bus.b),
        .sym     (bus.tmds_ch0)
`ifdef DVI_DISP_CHECK_EN
        ,
        .err     (err_ch0)
`endif
    );

    tmds_encoder #(.DISPW(DISPW)) u_enc_g (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .de      (bus.de),
        .c0      (1'b0),
        .c1      (1'b0),
        .d       (bus.g),
        .sym     (bus.tmds_ch1)
`ifdef DVI_DISP_CHECK_EN
        ,
        .err     (err_ch1)
`endif
    );

    tmds_encoder #(.DISPW(DISPW)) u_enc_r (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .de      (bus.de),
        .c0      (1'b0),
        .c1      (1'b0),
        .d       (bus.r),
        .sym     (bus.tmds_ch2)
`ifdef DVI_DISP_CHECK_EN
        ,
        .err     (err_ch2)
`endif
    );

`ifdef DVI_DISP_CHECK_EN
    assign bus.disp_err = err_ch0 | err_ch1 | err_ch2;
`else
    assign bus.disp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dvi_encoder.sv
// Scoreboard bench for dvi_encoder: directed vectors plus randomized pixel/blanking runs.
module tb_dvi_encoder;

    localparam int unsigned DISPW = 6;
    localparam int NDir  = 17;
    localparam int NRand = 10000;
    localparam int NTot  = NDir + NRand;

    typedef struct {
        bit         rst;
        bit         de;
        bit         hs;
        bit         vs;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        int         gold;
    } item_t;

    typedef struct {
        int         due;
        int         idx;
        logic [9:0] ch0;
        logic [9:0] ch1;
        logic [9:0] ch2;
    } exp_t;

    logic clk_pix = 1'b0;
    logic rst_pix;

    dvi_encoder_if bus ();

    dvi_encoder #(.DISPW(DISPW)) dut (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .bus     (bus)
    );

    always #5 clk_pix = ~clk_pix;

    int cyc = 0;
    always @(posedge clk_pix) cyc <= cyc + 1;

    item_t items[NTot];
    exp_t  sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cnt_m[3];
    bit    stim_done = 1'b0;

    function automatic int wrap(input int v);
        int m;
        int h;
        m = 1 << DISPW;
        h = m / 2;
        return (((v + h) % m) + m) % m - h;
    endfunction

    function automatic logic [9:0] token(input bit c1, input bit c0);
        logic [9:0] t;
        case ({c1, c0})
            2'b00:   t = 10'h354;
            2'b01:   t = 10'h0AB;
            2'b10:   t = 10'h154;
            default: t = 10'h2AB;
        endcase
        return t;
    endfunction

    // q_m bit i is the parity of d[i:0], inverted at odd positions when XNOR chaining.
    function automatic logic [9:0] encode(input int ch, input logic [7:0] d);
        int         n1;
        int         ones;
        int         bal;
        int         delta;
        bit         inv;
        bit         par;
        bit         q8;
        logic [7:0] q;
        logic [9:0] s;
        n1  = $countones(d);
        inv = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        par = 1'b0;
        for (int i = 0; i < 8; i++) begin
            par  = par ^ d[i];
            q[i] = par ^ (inv && (i % 2 == 1));
        end
        q8   = !inv;
        ones = $countones(q);
        bal  = ones - (8 - ones);
        if (cnt_m[ch] == 0 || bal == 0) begin
            s     = {~q8, q8, q8 ? q : ~q};
            delta = q8 ? bal : -bal;
        end else if ((cnt_m[ch] > 0 && bal > 0) || (cnt_m[ch] < 0 && bal < 0)) begin
            s     = {1'b1, q8, ~q};
            delta = 2 * int'(q8) - bal;
        end else begin
            s     = {1'b0, q8, q};
            delta = -2 * int'(!q8) + bal;
        end
        cnt_m[ch] = wrap(cnt_m[ch] + delta);
        return s;
    endfunction

    function automatic logic [7:0] rand_pix();
        logic [7:0] v;
        case ($urandom_range(7))
            0:       v = 8'h00;
            1:       v = 8'hFF;
            default: v = 8'($urandom);
        endcase
        return v;
    endfunction

    task automatic set_item(input int i, input bit rst, input bit de, input bit hs, input bit vs,
                            input logic [7:0] b, input int gold);
        items[i].rst  = rst;
        items[i].de   = de;
        items[i].hs   = hs;
        items[i].vs   = vs;
        items[i].r    = rand_pix();
        items[i].g    = rand_pix();
        items[i].b    = b;
        items[i].gold = gold;
    endtask

    task automatic check(input string name, input int idx, input logic [9:0] act,
                         input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s item %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic build_items();
        int run;
        bit de_r;
        for (int i = 0; i < 3; i++) set_item(i, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, -1);
        set_item(3,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 'h354);
        set_item(4,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 'h354);
        set_item(5,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 'h100);
        set_item(6,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 'h3FF);
        set_item(7,  1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 'h100);
        set_item(8,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 'h354);
        set_item(9,  1'b0, 1'b1, 1'b0, 1'b0, 8'hFF, 'h200);
        set_item(10, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 'h0AB);
        set_item(11, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 'h154);
        set_item(12, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 'h100);
        // Item 13 is flushed by the reset sampled with item 14.
        set_item(13, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 'h354);
        set_item(14, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 'h354);
        set_item(15, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 'h100);
        set_item(16, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 'h3FF);
        run  = 0;
        de_r = 1'b0;
        for (int i = NDir; i < NTot; i++) begin
            if (run == 0) begin
                de_r = !de_r;
                run  = de_r ? int'($urandom_range(40, 1)) : int'($urandom_range(12, 1));
            end
            run--;
            set_item(i, ($urandom_range(1999) == 0), de_r, 1'($urandom), 1'($urandom),
                     rand_pix(), -1);
        end
    endtask

    initial begin
        exp_t e;
        bit   next_rst;
        rst_pix   = 1'b1;
        bus.de    = 1'b0;
        bus.hsync = 1'b0;
        bus.vsync = 1'b0;
        bus.r     = 8'h00;
        bus.g     = 8'h00;
        bus.b     = 8'h00;
        cnt_m     = '{0, 0, 0};
        build_items();
        for (int i = 0; i < NTot; i++) begin
            @(posedge clk_pix);
            #1;
            rst_pix   = items[i].rst;
            bus.de    = items[i].de;
            bus.hsync = items[i].hs;
            bus.vsync = items[i].vs;
            bus.r     = items[i].r;
            bus.g     = items[i].g;
            bus.b     = items[i].b;
            e.due     = cyc + 2;
            e.idx     = i;
            next_rst  = (i + 1 < NTot) ? items[i+1].rst : 1'b0;
            if (next_rst || items[i].rst || !items[i].de) begin
                e.ch0 = (next_rst || items[i].rst) ? 10'h354 : token(items[i].vs, items[i].hs);
                e.ch1 = 10'h354;
                e.ch2 = 10'h354;
                cnt_m = '{0, 0, 0};
            end else begin
                e.ch0 = encode(0, items[i].b);
                e.ch1 = encode(1, items[i].g);
                e.ch2 = encode(2, items[i].r);
            end
            if (items[i].gold >= 0) e.ch0 = 10'(items[i].gold);
            sb.push_back(e);
        end
        @(posedge clk_pix);
        #1;
        rst_pix = 1'b0;
        bus.de  = 1'b0;
        repeat (4) @(posedge clk_pix);
        stim_done = 1'b1;
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clk_pix);
            while (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                check("ch0", e.idx, bus.tmds_ch0, e.ch0);
                check("ch1", e.idx, bus.tmds_ch1, e.ch1);
                check("ch2", e.idx, bus.tmds_ch2, e.ch2);
                check("disp_err", e.idx, 10'(bus.disp_err), 10'h000);
            end
        end
    end

    initial begin
        wait (stim_done);
        @(negedge clk_pix);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #(20 * NTot + 1000);
        $display("FAIL timeout: got no end of stimulus, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dvi_encoder.md
# dvi_encoder

Three-channel DVI TMDS encoder. It sits directly downstream of the display timing generator, fed by its `de`, `hsync` and `vsync` plus pixel colour from the drawing logic. It produces three 10-bit TMDS symbols per pixel clock for the serialiser stage. It carries DC-balancing state (running disparity) per channel and uses a fixed two-stage pipeline.

## Interface
- `DISPW`, default 6: signed running-disparity register width in bits; must be ≥5.
- `clk_pix` in 1: pixel clock.
- `rst_pix` in 1: synchronous, active-high reset in the pixel clock domain.
- `de` in 1: data enable (high = active pixel).
- `hsync` in 1: horizontal sync, already at final polarity.
- `vsync` in 1: vertical sync, already at final polarity.
- `r` in 8: red pixel value.
- `g` in 8: green pixel value.
- `b` in 8: blue pixel value.
- `tmds_ch0` out 10: blue channel symbol; carries hsync/vsync during blanking.
- `tmds_ch1` out 10: green channel symbol.
- `tmds_ch2` out 10: red channel symbol.
- `disp_err` out 1: sticky disparity-bound error flag (see Configuration).

## Operation
- Stage 1 handles each channel independently:
  - Compute N1(D), the number of ones in the 8-bit input.
  - If N1>4, or N1==4 with D[0]==0: use XNOR chaining. q_m[0]=D[0], q_m[i]=q_m[i-1] XNOR D[i], q_m[8]=0.
  - Otherwise use XOR chaining with q_m[8]=1.
  - Register q_m, its N1/N0 counts, de, and the control bits.
- Stage 2, when de=1 (cnt is the running disparity, signed `DISPW` bits):
  - If cnt==0 or N1(q_m)==N0(q_m): out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}. cnt += q_m[8] ? (N1−N0) : (N0−N1).
  - Else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out = {1, q_m[8], ~q_m[7:0]}. cnt += 2·q_m[8] + (N0−N1).
  - Else: out = {0, q_m[8], q_m[7:0]}. cnt += −2·(~q_m[8]) + (N1−N0).
- Stage 2, when de=0:
  - Emit a control token and clear cnt to 0.
  - Tokens for {c1,c0}: 00→10'b1101010100, 01→10'b0010101011, 10→10'b0101010100, 11→10'b1010101011.
  - ch0 uses c0=hsync, c1=vsync. ch1 and ch2 use {0,0}.
- Arithmetic:
  - Counts are 4-bit unsigned.
  - All disparity maths is done signed at `DISPW` bits; no saturation.
  - The legal range is −8..+8 by construction.
- Reset:
  - All three outputs = 10'b1101010100.
  - ch0 = token for the reset-time syncs is not used; reset value is fixed at the {0,0} token.
  - cnt=0 on all channels; pipeline de cleared; `disp_err`=0.
  - Reset mid-line aborts in-flight pixels. Outputs show the reset token in the cycle after `rst_pix` is sampled high.

## Timing
- Latency: exactly 2 `clk_pix` cycles from inputs to `tmds_chN`, for both data and control.
- Throughput: one symbol per channel per cycle. No stalls and no handshake; inputs are sampled every cycle.
- de transitions:
  - The first active pixel after blanking always starts from cnt=0.
  - The first blanking cycle after active emits a token; cnt clears on that same edge.
- Simultaneous de=0 with hsync/vsync change: the token reflects the syncs sampled two cycles earlier.

## Configuration
- `DVI_DISP_CHECK_EN` defined:
  - `disp_err` sets on the cycle after any channel's updated cnt falls outside −8..+8.
  - It stays set until `rst_pix`.
- Not defined: `disp_err` is tied to 0 and no check logic is built. Symbol outputs are identical in both builds.

## Structure
- Package `dvi_pkg` holds:
  - the four control token localparams (`TMDS_CTRL_00` … `TMDS_CTRL_11`);
  - typedef `tmds_sym_t` (logic [9:0]);
  - the disparity bound constant (8).
- Sub-module `tmds_encoder`:
  - single-channel, two-stage encoder with inputs de, c0, c1, d[7:0] and output 10-bit symbol (plus per-channel err when enabled);
  - instantiated three times by `dvi_encoder`, which ORs the per-channel errors.

## Test plan
- Reset: hold `rst_pix` 3 cycles → all channels 10'h354 (1101010100), `disp_err`=0.
- Blue 0x00 for three consecutive de=1 pixels after blanking → ch0 = 10'h100, 10'h3FF, 10'h100 on cycles +2, +3, +4; cnt = −8, +2, −6.
- Blue 0xFF, one pixel, from cnt=0 → ch0 = 10'h200; cnt = −8.
- Blanking: de=0 with hsync=1, vsync=0 → ch0 = 10'h0AB, ch1 = ch2 = 10'h354 two cycles later. With hsync=0, vsync=1 → ch0 = 10'h154.
- Random 10k pixels with random de runs, compared against a behavioural model → all symbols match; with `DVI_DISP_CHECK_EN`, `disp_err` stays 0.
- Assert `rst_pix` for one cycle mid-line with cnt≠0, then resume de=1 with blue 0x00 → reset token appears, and the first data symbol is 10'h100 (cnt restarted at 0).
